// File: rtl/demux9_pkg.sv
// Shared constants, index type and select helpers for the 1-to-9 stream distributor.
package demux9_pkg;

    localparam int unsigned NCH        = 9;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned IDXW       = 4;

    typedef logic [IDXW-1:0] chidx_t;

    // Lowest-set-bit encoder; a zero-hot select yields index 0.
    function automatic chidx_t oh2idx(input logic [NCH-1:0] sel);
        chidx_t idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one select bit is set.
    function automatic logic is_onehot(input logic [NCH-1:0] sel);
        return (sel != '0) && ((sel & (sel - NCH'(1))) == '0);
    endfunction

endpackage

// File: rtl/demux9_stream_if.sv
// Producer-side handshake plus the per-channel consumer bus of demux9_stream.
interface demux9_stream_if #(
    parameter int unsigned DW = 1
);
    import demux9_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [NCH-1:0]     in_sel;
    logic [DW-1:0]      in_data;
    logic [NCH-1:0]     out_valid;
    logic [NCH-1:0]     out_ready;
    logic [DW-1:0]      out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux9_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; push when full and pop when empty are ignored.
module demux9_fifo2
    import demux9_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic [W-1:0] mem_d [FIFO_DEPTH];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state: write behind the head, advance pointers, track occupancy.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ~wptr_q;
        end
        if (pop_ok) begin
            rptr_d = ~rptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/demux9_stream.sv
// 1-to-9 stream distributor: encodes a one-hot select, buffers {index,data} in a
// 2-entry FIFO and fans the head out as a per-channel valid on a shared data bus.
// Optional select checking is enabled with `define DEMUX9_ONEHOT_CHECK_EN.
module demux9_stream
    import demux9_pkg::*;
#(
    parameter int unsigned DW = 1
) (
    input  logic              clk,
    input  logic              nreset,
    demux9_stream_if.slave    bus,
    output logic              err_onehot,
    input  logic              err_clr
);

    localparam int unsigned FW = DW + IDXW;

    logic          run_q, run_d;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [FW-1:0] wdata;
    logic [FW-1:0] rdata;
    chidx_t        head_idx;
    logic [NCH-1:0] head_valid;

    // in_ready is held low through reset and rises on the first edge after release.
    always_comb begin
        run_d = 1'b1;
    end

    // Run flag register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    // Accept/push/pop decode; zero-hot selects complete the handshake but are dropped.
    always_comb begin
        accept     = bus.in_valid & bus.in_ready;
        push       = accept & (|bus.in_sel);
        wdata      = {oh2idx(bus.in_sel), bus.in_data};
        head_idx   = rdata[FW-1 -: IDXW];
        head_valid = empty ? '0 : (NCH'(1) << head_idx);
        pop        = |(head_valid & bus.out_ready);
    end

    assign bus.in_ready  = run_q & ~full;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = empty ? '0 : rdata[DW-1:0];

    demux9_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (pop),
        .wdata  (wdata),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

`ifdef DEMUX9_ONEHOT_CHECK_EN
    logic err_q, err_d;

    // Sticky select error; a bad accept in the same cycle as a clear keeps it set.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (accept && !is_onehot(bus.in_sel)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_onehot = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_onehot     = 1'b0;
`endif

endmodule

// File: doc/demux9_stream.md
Name: demux9_stream

Overview:
- 1-to-9 stream distributor; the write-side counterpart of the 9-way one-hot AND-OR select mux.
- Accepts a data word tagged with a 9-bit one-hot destination select over a valid/ready handshake and buffers it in a 2-entry FIFO.
- Presents the word on a shared output data bus with a per-channel valid, and pops it when the addressed channel's ready is high.
- Sits between a single producer and up to nine consumers; the consumers' return path is merged by the one-hot mux.

Parameters:
- DW, 1, data width in bits

Ports:
- clk  input  1  clock
- nreset  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word this cycle
- in_sel  input  9  one-hot destination select; bit k selects channel k
- in_data  input  DW  word to route
- out_valid  output  9  per-channel valid, at most one bit set
- out_ready  input  9  per-channel consumer ready
- out_data  output  DW  shared data bus, meaningful only where out_valid is set
- err_onehot  output  1  sticky select-error flag; tied 0 without the optional feature
- err_clr  input  1  clears err_onehot; ignored without the optional feature

Behaviour:
- Reset:
  - Only clk and nreset; nreset sampled on the rising clk edge, active low.
  - During reset: FIFO empty, out_valid=0, out_data=0, in_ready=0, err_onehot=0.
  - in_ready rises on the first edge after nreset goes high.
  - Reset mid-transfer discards all buffered words; no partial handshake survives reset.
- Accept: push occurs when in_valid & in_ready at the clock edge.
  - in_sel is encoded to a 4-bit index, lowest set bit wins.
  - Index and data are stored together.
- Zero-hot select: in_sel==0 is still accepted (in_valid & in_ready completes), the word is discarded, and the FIFO is not written.
- FIFO:
  - 2 entries; count ranges 0..2.
  - in_ready = (count<2), driven from registers only; no combinational path from out_ready or in_valid.
- Output:
  - Head entry drives out_data and sets out_valid[head_idx].
  - Pop occurs when out_valid[head_idx] & out_ready[head_idx].
  - out_ready bits of non-addressed channels are ignored.
- Latency:
  - A word accepted at edge N into an empty FIFO appears on out_valid/out_data after edge N; one cycle latency.
  - Throughput is 1 word/cycle when the consumer is always ready.
- Simultaneous push and pop:
  - count unchanged; the new word goes behind the popped head.
  - At count==2, push is impossible because in_ready=0.
  - A pop at count==2 raises in_ready on the following cycle.
- Ordering: strictly FIFO across all channels. A stalled head blocks later words, even those addressed to other channels; there is no reordering.
- out_data and out_valid hold stable while the head is not popped.
- Pointers: 1-bit read and write pointers that wrap modulo 2.

Optional Feature:
- Macro: DEMUX9_ONEHOT_CHECK_EN.
- When defined:
  - err_onehot is set at any accept edge where in_sel is zero-hot or has more than one bit set.
  - Routing still uses the lowest set bit.
  - err_onehot stays set until err_clr is high at an edge or reset.
  - If set and clear occur in the same cycle, set wins.
- When undefined:
  - err_onehot is constant 0 and err_clr is unused.
  - No check logic is synthesised.
  - Routing is unchanged.

Decomposition:
- Package demux9_pkg holds:
  - constant NCH=9
  - constant FIFO_DEPTH=2
  - typedef chidx_t (4-bit index)
  - function oh2idx (lowest-set-bit encoder returning chidx_t)
  - function is_onehot
- One sub-module: demux9_fifo2, a 2-entry FIFO with params DW+4.
  - Ports: clk, nreset, push, pop, wdata, rdata, full, empty.
- Top level: encoder, zero-hot drop, valid fan-out and error flag.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with in_valid=1 -> in_valid must be ignored, and in_ready, out_valid, out_data and err_onehot must all be 0. Release -> in_ready=1 on the next cycle.
- Single route: in_sel=9'h010, in_data=8'hA5 (DW=8), all out_ready=1 -> out_valid=9'h010 and out_data=8'hA5 one cycle later, then 0.
- Backpressure: push to channels 2,5,7 with out_ready=0 -> in_ready=0 after the second accept. Raise out_ready[2] -> channel-2 word pops and in_ready=1 the next cycle. out_ready[7]=1 alone must not pop the channel-5 head.
- Streaming: 20 back-to-back words, sel cycling 1<<(i%9), all ready=1 -> 20 outputs in order at 1/cycle, no bubbles.
- Zero-hot and multi-hot: in_sel=0 -> accepted, no output. in_sel=9'h006 -> delivered on channel 1. With DEMUX9_ONEHOT_CHECK_EN, err_onehot=1 after the first bad accept. err_clr for 1 cycle -> 0. Without the macro, err_onehot stays 0.
- Mid-operation reset: 2 words buffered, nreset=0 for 1 cycle -> out_valid=0. After release, no stale word ever appears.
